// File: rtl/mem_arb_pkg.sv
// Shared types and command encodings for the memory request arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    function automatic logic [1:0] cmd_for(input logic we);
        return we ? CMD_WRITE : CMD_READ;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_rr_picker.sv
// Combinational round-robin picker: lowest request strictly above `last`,
// otherwise lowest request overall (wrap-around).
module rr_picker #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last,
    output logic              any,
    output logic [IDX_W-1:0]  grant
);

    logic [NUM_CH-1:0] masked;

    always_comb begin
        masked = '0;
        any    = |req;
        grant  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            masked[i] = req[i] && (IDX_W'(i) > last);
        end
        // Scan downward so the lowest qualifying index is the one left standing.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (|masked) begin
                if (masked[i]) grant = IDX_W'(i);
            end else if (req[i]) begin
                grant = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// N-channel round-robin front end for the memory controller: one transaction
// in flight, completion routed back to the granted channel, watchdog error return.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_we,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]        ch_ack,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [NUM_CH-1:0]        ch_err,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     busy,
    output logic [1:0]               mc_cmd,
    output logic [ADDR_W-1:0]        mc_addr,
    output logic [DATA_W-1:0]        mc_wdata,
    output logic                     mc_ready,
    input  logic                     mc_valid,
    input  logic [DATA_W-1:0]        mc_rdata
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    function automatic logic [NUM_CH-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t              state_q;
    logic [IDX_W-1:0]    last_q, gnt_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [NUM_CH-1:0]   ack_q, done_q, err_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                busy_q, mc_ready_q;
    logic [1:0]          cmd_q;
    logic [ADDR_W-1:0]   mc_addr_q, addr_q;
    logic [DATA_W-1:0]   mc_wdata_q, wdata_q;
    logic                we_q;
    logic                pick_any;
    logic [IDX_W-1:0]    pick_idx;

    rr_picker #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_picker (
        .req   (ch_req),
        .last  (last_q),
        .any   (pick_any),
        .grant (pick_idx)
    );

    // Request fields are pure data: captured at grant, no reset needed.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && pick_any) begin
            we_q    <= ch_we[pick_idx];
            addr_q  <= ch_addr[pick_idx*ADDR_W +: ADDR_W];
            wdata_q <= ch_wdata[pick_idx*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= IDX_W'(NUM_CH - 1);
            gnt_q      <= '0;
            cnt_q      <= '0;
            ack_q      <= '0;
            done_q     <= '0;
            err_q      <= '0;
            rd_data_q  <= '0;
            busy_q     <= 1'b0;
            mc_ready_q <= 1'b0;
            cmd_q      <= CMD_NONE;
            mc_addr_q  <= '0;
            mc_wdata_q <= '0;
        end else begin
            ack_q      <= '0;
            done_q     <= '0;
            err_q      <= '0;
            mc_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cmd_q <= CMD_NONE;
                    if (pick_any) begin
                        ack_q   <= onehot(pick_idx);
                        last_q  <= pick_idx;
                        gnt_q   <= pick_idx;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    cmd_q      <= cmd_for(we_q);
                    mc_addr_q  <= addr_q;
                    mc_wdata_q <= wdata_q;
                    mc_ready_q <= 1'b1;
                    cnt_q      <= '0;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    // A completion arriving on the last watchdog cycle still counts as success.
                    if (mc_valid) begin
                        done_q  <= onehot(gnt_q);
                        if (!we_q) rd_data_q <= mc_rdata;
                        cnt_q   <= '0;
                        cmd_q   <= CMD_NONE;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        done_q  <= onehot(gnt_q);
                        err_q   <= onehot(gnt_q);
                        cnt_q   <= '0;
                        cmd_q   <= CMD_NONE;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    cmd_q   <= CMD_NONE;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ch_ack   = ack_q;
    assign ch_done  = done_q;
    assign ch_err   = err_q;
    assign rd_data  = rd_data_q;
    assign busy     = busy_q;
    assign mc_cmd   = cmd_q;
    assign mc_addr  = mc_addr_q;
    assign mc_wdata = mc_wdata_q;
    assign mc_ready = mc_ready_q;

endmodule
